// File: rtl/sprite_queue_pkg.sv
// Shared addresses, entry layout and FSM states for the sprite update queue.
package sprite_queue_pkg;

  localparam logic [5:0] ADDR_CLEAR   = 6'd60;
  localparam logic [5:0] ADDR_STATUS  = 6'd62;
  localparam logic [5:0] ADDR_OVF_CLR = 6'd63;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/sprite_update_queue_fifo.sv
// Synchronous FIFO of sprite-register commands; a push while full is
// accepted only if a pop frees a slot in the same cycle.
module sprite_fifo
  import sprite_queue_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  entry_t                   wdata,
  output entry_t                   rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/sprite_update_queue.sv
// Host-side queue of sprite-register writes, drained during vertical blank.
// Optional frame counter in status bits 30:16: SPRITE_QUEUE_FRAMECNT_EN.
module sprite_update_queue
  import sprite_queue_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [5:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        vblank,
  output logic        out_write,
  output logic [5:0]  out_address,
  output logic [31:0] out_data,
  output logic        busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t        state_q, state_d;
  logic          vblank_s_q, vblank_q;
  logic          rise;
  logic          ovf_q, ovf_d;
  logic [31:0]   readdata_q, readdata_d;
  logic          out_write_q, out_write_d;
  logic [5:0]    out_address_q, out_address_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          push_req;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] fifo_count;
  logic [14:0]   frame_bits;
  entry_t        wr_entry;
  entry_t        head;

  assign rise     = vblank_s_q && !vblank_q;
  assign push_req = chipselect && write && (address <= ADDR_CLEAR);
  assign wr_entry = '{addr: address, data: writedata};

  sprite_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

`ifdef SPRITE_QUEUE_FRAMECNT_EN
  logic [14:0] frame_q, frame_d;

  always_comb begin
    frame_d = frame_q;
    if (rise) frame_d = frame_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_q <= '0;
    else       frame_q <= frame_d;
  end

  assign frame_bits = frame_q;
`else
  assign frame_bits = '0;
`endif

  // Leave DRAIN once the queue is seen empty or blanking has ended.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise && !empty) state_d = DRAIN;
      end
      DRAIN: begin
        if (!vblank_s_q || empty) state_d = IDLE;
        else                      pop     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ovf_d         = ovf_q;
    readdata_d    = '0;
    out_write_d   = pop;
    out_address_d = out_address_q;
    out_data_d    = out_data_q;
    if (chipselect && write && address == ADDR_OVF_CLR)
      ovf_d = 1'b0;
    else if (push_req && full && !pop)
      ovf_d = 1'b1;
    if (chipselect && read && address == ADDR_STATUS)
      readdata_d = {ovf_q, frame_bits, 8'b0, 8'(fifo_count)};
    if (pop) begin
      out_address_d = head.addr;
      out_data_d    = head.data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      vblank_s_q    <= 1'b0;
      vblank_q      <= 1'b0;
      ovf_q         <= 1'b0;
      readdata_q    <= '0;
      out_write_q   <= 1'b0;
      out_address_q <= '0;
      out_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      vblank_s_q    <= vblank;
      vblank_q      <= vblank_s_q;
      ovf_q         <= ovf_d;
      readdata_q    <= readdata_d;
      out_write_q   <= out_write_d;
      out_address_q <= out_address_d;
      out_data_q    <= out_data_d;
    end
  end

  assign readdata    = readdata_q;
  assign out_write   = out_write_q;
  assign out_address = out_address_q;
  assign out_data    = out_data_q;
  assign busy        = (state_q == DRAIN);

endmodule

// File: tb/tb_sprite_update_queue.sv
// Directed bench for sprite_update_queue with hand-computed expectations.
module tb_sprite_update_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [5:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        vblank = 1'b0;
  logic        out_write;
  logic [5:0]  out_address;
  logic [31:0] out_data;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int frames = 0;
  int npop;
  logic seen;
  logic [31:0] got [16];

  sprite_update_queue #(.DEPTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .chipselect  (chipselect),
    .write       (write),
    .read        (read),
    .address     (address),
    .writedata   (writedata),
    .readdata    (readdata),
    .vblank      (vblank),
    .out_write   (out_write),
    .out_address (out_address),
    .out_data    (out_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a);
    chipselect = 1'b1; read = 1'b1; address = a;
    tick();
    chipselect = 1'b0; read = 1'b0;
  endtask

  function automatic logic [31:0] status(input logic ovf, input int fr,
                                         input int cnt);
    logic [14:0] f;
`ifdef SPRITE_QUEUE_FRAMECNT_EN
    f = 15'(fr);
`else
    f = 15'd0;
`endif
    return {ovf, f, 8'b0, 8'(cnt)};
  endfunction

  initial begin
    repeat (3) tick();
    check("rst_readdata", readdata, 32'h0);
    check("rst_out_write", {31'b0, out_write}, 32'h0);
    check("rst_out_address", {26'b0, out_address}, 32'h0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    reset = 1'b0;
    tick();

    // Single entry held while vblank stays low.
    wr(6'd3, 32'h0012_0040);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (out_write) seen = 1'b1;
    end
    check("idle_no_write", {31'b0, seen}, 32'h0);
    rd(6'd62);
    check("status_cnt1", readdata, status(1'b0, frames, 1));

    vblank = 1'b1; frames++;
    tick(); tick();
    check("single_early", {31'b0, out_write}, 32'h0);
    tick();
    check("single_ow", {31'b0, out_write}, 32'h1);
    check("single_addr", {26'b0, out_address}, 32'd3);
    check("single_data", out_data, 32'h0012_0040);
    tick();
    check("single_done", {31'b0, out_write}, 32'h0);
    vblank = 1'b0;
    repeat (3) tick();

    // Four entries drained in order starting two cycles after the edge.
    for (int i = 0; i < 4; i++) wr(6'(i), 32'hA0 + i);
    vblank = 1'b1; frames++;
    tick(); tick();
    check("burst_early", {31'b0, out_write}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("burst_ow", {31'b0, out_write}, 32'h1);
      check("burst_addr", {26'b0, out_address}, i);
      check("burst_data", out_data, 32'hA0 + i);
      check("burst_busy", {31'b0, busy}, 32'h1);
    end
    tick();
    check("burst_ow_end", {31'b0, out_write}, 32'h0);
    check("burst_busy_end", {31'b0, busy}, 32'h0);
    check("burst_addr_hold", {26'b0, out_address}, 32'd3);
    vblank = 1'b0;
    repeat (3) tick();
    rd(6'd62);
    check("status_empty", readdata, status(1'b0, frames, 0));

    // Overflow on DEPTH+1 pushes, then clear; 61/62 writes ignored.
    for (int i = 0; i < 33; i++) wr(6'd5, i);
    rd(6'd62);
    check("ovf_set", readdata, status(1'b1, frames, 32));
    wr(6'd63, 32'h0);
    wr(6'd61, 32'h1);
    wr(6'd62, 32'h2);
    rd(6'd62);
    check("ovf_clr", readdata, status(1'b0, frames, 32));
    rd(6'd5);
    check("rd_other", readdata, 32'h0);
    vblank = 1'b1; frames++;
    tick();
    npop = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_write) begin
        check("full_order", out_data, npop);
        npop++;
      end
    end
    check("full_npop", npop, 32);
    vblank = 1'b0;
    repeat (3) tick();

    // Short blank: partial drain, remainder on the next blank.
    for (int i = 0; i < 10; i++) wr(6'(i), 32'h100 + i);
    vblank = 1'b1; frames++;
    npop = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) vblank = 1'b0;
      tick();
      if (out_write) begin
        check("short_order", out_data, 32'h100 + npop);
        npop++;
      end
    end
    check("short_le3", {31'b0, (npop <= 3)}, 32'h1);
    check("short_ge1", {31'b0, (npop >= 1)}, 32'h1);
    rd(6'd62);
    check("short_remain", readdata, status(1'b0, frames, 10 - npop));
    vblank = 1'b1; frames++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_write) begin
        check("rest_order", out_data, 32'h100 + npop);
        check("rest_addr", {26'b0, out_address}, npop);
        npop++;
      end
    end
    check("rest_total", npop, 10);
    vblank = 1'b0;
    repeat (3) tick();

    // Reset in the middle of a drain.
    for (int i = 0; i < 5; i++) wr(6'(i), 32'h200 + i);
    vblank = 1'b1;
    tick(); tick(); tick();
    check("rst_mid_ow", {31'b0, out_write}, 32'h1);
    #1 reset = 1'b1;
    #1;
    check("rst_async_ow", {31'b0, out_write}, 32'h0);
    check("rst_async_busy", {31'b0, busy}, 32'h0);
    vblank = 1'b0;
    tick(); tick();
    reset = 1'b0;
    frames = 0;
    tick();
    rd(6'd62);
    check("rst_count0", readdata, status(1'b0, frames, 0));
    vblank = 1'b1; frames++;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_write) seen = 1'b1;
    end
    check("rst_no_out", {31'b0, seen}, 32'h0);
    check("empty_idle", {31'b0, busy}, 32'h0);
    vblank = 1'b0;
    repeat (3) tick();

    // Frame counter after a fresh reset and three blanks.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    frames = 0;
    tick();
    for (int p = 0; p < 3; p++) begin
      vblank = 1'b1; frames++;
      repeat (4) tick();
      vblank = 1'b0;
      repeat (4) tick();
    end
    rd(6'd62);
    check("frame_cnt", readdata, status(1'b0, 3, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_update_queue.md
SPRITE_UPDATE_QUEUE -- requirements
Module: sprite_update_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 32, FIFO entries (power of two, 4..64).
REQ-002 SHALL have port clk  in  1  single clock for all logic.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports chipselect, write, read  in  1 each  Avalon slave strobes from the host.
REQ-005 SHALL have port address  in  6  Avalon word address.
REQ-006 SHALL have port writedata  in  32  Avalon write data.
REQ-007 SHALL have port readdata  out  32  registered Avalon read data.
REQ-008 SHALL have port vblank  in  1  level-high vertical-blank indication from display timing.
REQ-009 SHALL have ports out_write (1), out_address (6), out_data (32)  out  sprite-register write command to the downstream sprite table.
REQ-010 SHALL have port busy  out  1  high while in DRAIN.

Function
REQ-011 Write with chipselect, address 0..60 SHALL push {address, writedata} into the FIFO; the entry is poppable the next cycle.
REQ-012 Push while full SHALL be dropped and SHALL set the sticky overflow flag; if a pop occurs in the same cycle, the push SHALL be accepted.
REQ-013 Write to address 63 SHALL clear overflow the same cycle and SHALL NOT push; writes to 61/62 SHALL be ignored.
REQ-014 Read with chipselect at address 62 SHALL return, one cycle later, {overflow[31], frame_count[30:16], 8'b0, count[7:0]}; other addresses SHALL return 0.
REQ-015 FSM states IDLE, DRAIN; IDLE->DRAIN on vblank rising edge (registered edge detect) when FIFO non-empty.
REQ-016 In DRAIN, one entry SHALL pop per cycle and appear on out_write=1/out_address/out_data for exactly one cycle.
REQ-017 DRAIN->IDLE when FIFO becomes empty or vblank is low; a pop already issued SHALL complete, no further pops.
REQ-018 Pushes during DRAIN SHALL be accepted and drained in the same blank if vblank stays high.
REQ-019 Entries SHALL emerge in push order; address 60 (clear-all) SHALL be forwarded unchanged as an ordinary command.
REQ-020 out_write SHALL be 0 in IDLE; out_address/out_data hold last value when out_write=0.
REQ-021 count SHALL be 0..DEPTH, with pointers wrapping modulo DEPTH.
REQ-022 Vblank rising edge with empty FIFO SHALL leave state IDLE.

Reset
REQ-023 Reset SHALL clear FIFO pointers, count, overflow, frame_count, and edge register; state SHALL be IDLE; readdata, out_write, out_address, out_data, busy SHALL be 0.
REQ-024 Reset asserted mid-DRAIN SHALL discard all queued entries; out_write SHALL drop to 0 immediately (asynchronously).

Configuration
REQ-025 With SPRITE_QUEUE_FRAMECNT_EN defined, a 15-bit frame_count SHALL increment (wrapping) on every vblank rising edge and appear in status bits 30:16.
REQ-026 Without SPRITE_QUEUE_FRAMECNT_EN, no counter SHALL be built and status bits 30:16 SHALL read 0.

Structure
REQ-027 Package sprite_queue_pkg SHALL hold: ADDR_CLEAR=60, ADDR_STATUS=62, ADDR_OVF_CLR=63, entry struct {6-bit addr, 32-bit data}, and the state enum.
REQ-028 The FIFO SHALL be a sub-module sprite_fifo (synchronous, DEPTH parameter, push/pop/full/empty/count, async active-high reset).

Verification
REQ-029 Push addr 3 data 0x0012_0040, vblank low 100 cycles -> out_write stays 0, status count=1.
REQ-030 Push 4 entries (addr 0..3), raise vblank -> 4 consecutive out_write pulses beginning 2 cycles after the vblank edge, in order, busy falls after the last.
REQ-031 Push DEPTH+1 entries with vblank low -> count=DEPTH, overflow=1; write addr 63 -> overflow=0, count unchanged.
REQ-032 Queue 10 entries, vblank high for 3 cycles -> at most 3 pops, remainder drained on the next vblank edge with order preserved.
REQ-033 Assert reset during DRAIN with 5 entries queued -> out_write 0 immediately, count=0, no further outputs at the next vblank.
REQ-034 With SPRITE_QUEUE_FRAMECNT_EN, 3 vblank pulses -> status bits 30:16 = 3; without it -> 0.
